rgbw_pwm_engine: RTL and testbench
==================================

RGBW_PWM_ENGINE -- requirements
Module: rgbw_pwm_engine

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all logic on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port tick_en, input, 1 bit: prescaled PWM advance enable; state advances only when high.
REQ-004 SHALL have port duty_vld, input, 1 bit: one-cycle strobe; the four duty inputs are valid this cycle.
REQ-005 SHALL have ports duty_r, duty_g, duty_b, duty_w, input, 8 bits each: requested duty for red, green, blue, white, 0..255.
REQ-006 SHALL have port pwm_out, output, 4 bits: registered PWM drive; bit0 red, bit1 green, bit2 blue, bit3 white.
REQ-007 SHALL have port busy, output, 1 bit: high while a captured duty set waits for the next period boundary.
REQ-008 SHALL have port upd_ack, output, 1 bit: one-cycle pulse when a pending set becomes active.
REQ-009 SHALL have port period_start, output, 1 bit: one-cycle pulse on each counter wrap.

Function
REQ-010 SHALL keep an 8-bit period counter cnt, counting 0..254 (period 255 ticks), incremented only on tick_en cycles; 254 wraps to 0.
REQ-011 SHALL define the wrap cycle as tick_en=1 with cnt=254; period_start SHALL be high on the cycle after each wrap cycle.
REQ-012 SHALL register pwm_out[k] <= (phase_k < act_k) on each tick_en cycle, where phase_k is channel k's phase and act_k its active duty; outputs hold when tick_en=0.
REQ-013 SHALL therefore yield: duty 0 constantly low, duty 255 constantly high, duty D high for exactly D of 255 ticks per period.
REQ-014 SHALL capture all four duty inputs into a pending register and set busy when duty_vld=1, regardless of tick_en.
REQ-015 SHALL let a later duty_vld overwrite an unapplied pending set (last write wins, no queue).
REQ-016 SHALL, on the wrap cycle with busy=1, copy pending to active, clear busy and pulse upd_ack on the next cycle; the first period using the new duties starts at cnt=0.
REQ-017 SHALL, when duty_vld and a wrap with busy=1 coincide, apply the old pending set, store the new inputs as pending and leave busy=1.
REQ-018 SHALL, when duty_vld coincides with a wrap with busy=0, not apply that set this wrap; it becomes pending and applies at the next wrap.
REQ-019 SHALL never change act_k other than at a wrap cycle, so no output glitches mid-period.
REQ-020 SHALL produce all outputs directly from flops.

Reset
REQ-021 SHALL, while reset=1 on a clock edge, set cnt=0, all active and pending duties=0, busy=0, upd_ack=0, period_start=0, pwm_out=4'b0000; reset overrides duty_vld and tick_en.
REQ-022 SHALL discard any pending set on reset mid-period; the first period after release starts at cnt=0.

Configuration
REQ-023 SHALL, with macro RGBW_PWM_STAGGER_EN defined, use phase_k = (cnt + 64*k) mod 255 (offsets 0, 64, 128, 192) to spread LED inrush edges.
REQ-024 SHALL, without RGBW_PWM_STAGGER_EN, use phase_k = cnt for all channels (edge-aligned); duty semantics of REQ-013 hold in both builds.

Structure
REQ-025 SHALL take DUTY_W=8, PWM_TOP=254, N_CH=4 and the channel index constants from shared package rgbw_pkg.
REQ-026 SHALL instantiate per-channel sub-module rgbw_pwm_channel (phase offset, compare, output flop), N_CH instances.

Verification
REQ-027 Reset, then tick_en=1 continuously: pwm_out=0000, period_start every 255 cycles, busy=0.
REQ-028 duty_vld with r=0, g=1, b=128, w=255 at cnt=10: busy=1 until wrap, upd_ack one cycle after wrap; next period high counts 0/1/128/255.
REQ-029 Two duty_vld strobes (r=50 then r=200) in one period: only r=200 applied; single upd_ack.
REQ-030 duty_vld on the wrap cycle with busy=1 (pending r=40, new r=90): r=40 applies now, busy stays 1, r=90 applies at next wrap.
REQ-031 tick_en toggling 1-of-4: pwm_out, cnt and period_start change only on enabled cycles; period = 1020 clocks.
REQ-032 STAGGER build, all duties=64: rising edges of channels 0..3 at cnt 0, 191, 127, 63; non-STAGGER: all rise at cnt 0; reset asserted mid-period clears outputs next edge.

Source files
------------

// File: rtl/rgbw_pkg.sv
// Shared constants, types and phase helper for the RGBW PWM engine.
// Build option: define RGBW_PWM_STAGGER_EN for staggered channel phases (default edge-aligned).
package rgbw_pkg;

    localparam int unsigned DUTY_W     = 8;
    localparam int unsigned N_CH       = 4;
    localparam int unsigned PWM_PERIOD = 255;
    localparam logic [DUTY_W-1:0] PWM_TOP = 8'd254;

    localparam int unsigned CH_R = 0;
    localparam int unsigned CH_G = 1;
    localparam int unsigned CH_B = 2;
    localparam int unsigned CH_W = 3;

`ifdef RGBW_PWM_STAGGER_EN
    localparam int unsigned PHASE_STEP = 64;
`else
    localparam int unsigned PHASE_STEP = 0;
`endif

    typedef logic [DUTY_W-1:0] duty_t;
    typedef duty_t [N_CH-1:0]  duty_set_t;

    typedef enum logic [0:0] {
        UPD_IDLE    = 1'b0,
        UPD_PENDING = 1'b1
    } upd_state_t;

    // Offsets never exceed one period, so a single conditional subtract is enough.
    function automatic duty_t phase_of(input duty_t cnt, input int unsigned ch);
        logic [DUTY_W:0] sum;
        sum = {1'b0, cnt} + (DUTY_W+1)'(PHASE_STEP * ch);
        if (sum >= (DUTY_W+1)'(PWM_PERIOD)) begin
            sum = sum - (DUTY_W+1)'(PWM_PERIOD);
        end
        return sum[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/rgbw_pwm_channel.sv
// One PWM channel: phase offset of the shared counter, duty compare and output flop.
// Phase offset follows rgbw_pkg::PHASE_STEP, which RGBW_PWM_STAGGER_EN controls.
module rgbw_pwm_channel
    import rgbw_pkg::*;
#(
    parameter int unsigned CH_IDX = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_en_i,
    input  logic [DUTY_W-1:0] cnt_i,
    input  logic [DUTY_W-1:0] duty_i,
    output logic              pwm_o
);

    logic [DUTY_W-1:0] phase;
    logic              pwm_d;
    logic              pwm_q;

    assign phase = phase_of(cnt_i, CH_IDX);

    // Phase covers 0..254 once per period, so duty D gives exactly D high ticks.
    always_comb begin
        pwm_d = pwm_q;
        if (tick_en_i) begin
            pwm_d = (phase < duty_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/rgbw_pwm_engine.sv
// Four-channel RGBW PWM engine with double-buffered duties applied only at period wrap.
// Build option RGBW_PWM_STAGGER_EN (see rgbw_pkg) staggers channel phases.
//
// state       | meaning
// UPD_IDLE    | no pending duty set; active duties in use
// UPD_PENDING | a captured set waits for the next wrap (busy=1)
module rgbw_pwm_engine
    import rgbw_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_en,
    input  logic              duty_vld,
    input  logic [DUTY_W-1:0] duty_r,
    input  logic [DUTY_W-1:0] duty_g,
    input  logic [DUTY_W-1:0] duty_b,
    input  logic [DUTY_W-1:0] duty_w,
    output logic [N_CH-1:0]   pwm_out,
    output logic              busy,
    output logic              upd_ack,
    output logic              period_start
);

    upd_state_t        state_q, state_d;
    logic [DUTY_W-1:0] cnt_q, cnt_d;
    duty_set_t         pend_q, pend_d;
    duty_set_t         act_q, act_d;
    duty_set_t         duty_in;
    logic              wrap;
    logic              apply;
    logic              upd_ack_q;
    logic              period_start_q;

    always_comb begin
        duty_in       = '0;
        duty_in[CH_R] = duty_r;
        duty_in[CH_G] = duty_g;
        duty_in[CH_B] = duty_b;
        duty_in[CH_W] = duty_w;
    end

    assign wrap  = tick_en && (cnt_q == PWM_TOP);
    assign apply = wrap && (state_q == UPD_PENDING);

    always_comb begin
        cnt_d = cnt_q;
        if (tick_en) begin
            cnt_d = (cnt_q == PWM_TOP) ? '0 : cnt_q + 1'b1;
        end
    end

    // Apply reads the old pending set, so a strobe on the wrap cycle lands behind it.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        act_d   = act_q;
        if (apply) begin
            act_d = pend_q;
        end
        if (duty_vld) begin
            pend_d = duty_in;
        end
        case (state_q)
            UPD_IDLE: begin
                if (duty_vld) begin
                    state_d = UPD_PENDING;
                end
            end
            UPD_PENDING: begin
                if (wrap && !duty_vld) begin
                    state_d = UPD_IDLE;
                end
            end
            default: state_d = UPD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= UPD_IDLE;
            cnt_q          <= '0;
            pend_q         <= '0;
            act_q          <= '0;
            upd_ack_q      <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pend_q         <= pend_d;
            act_q          <= act_d;
            upd_ack_q      <= apply;
            period_start_q <= wrap;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        rgbw_pwm_channel #(
            .CH_IDX (k)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .tick_en_i (tick_en),
            .cnt_i     (cnt_q),
            .duty_i    (act_q[k]),
            .pwm_o     (pwm_out[k])
        );
    end

    assign busy         = (state_q == UPD_PENDING);
    assign upd_ack      = upd_ack_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_rgbw_pwm_engine.sv
// Self-checking bench for rgbw_pwm_engine: per-cycle reference model plus directed literal checks.
module tb_rgbw_pwm_engine;

`ifdef RGBW_PWM_STAGGER_EN
    localparam int OFF = 64;
`else
    localparam int OFF = 0;
`endif

    logic       clk;
    logic       reset;
    logic       tick_en;
    logic       duty_vld;
    logic [7:0] duty_r, duty_g, duty_b, duty_w;
    logic [3:0] pwm_out;
    logic       busy, upd_ack, period_start;

    int n_vec = 0;
    int n_err = 0;

    rgbw_pwm_engine dut (
        .clk          (clk),
        .reset        (reset),
        .tick_en      (tick_en),
        .duty_vld     (duty_vld),
        .duty_r       (duty_r),
        .duty_g       (duty_g),
        .duty_b       (duty_b),
        .duty_w       (duty_w),
        .pwm_out      (pwm_out),
        .busy         (busy),
        .upd_ack      (upd_ack),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Position within the 255-tick period; a channel is high when its shifted
    // position lies below its duty.  Duty changes only take effect at a boundary.
    function automatic bit level(input int k, input int pos, input int duty);
        return ((pos + OFF * k) % 255) < duty;
    endfunction

    int         m_pos;
    int         m_act[4];
    int         m_pend[4];
    bit         m_pending;
    bit         m_live = 1'b0;
    logic [3:0] e_pwm;
    logic       e_busy, e_ack, e_ps;

    always @(posedge clk) begin
        int din[4];
        bit boundary;
        din[0] = int'(duty_r);
        din[1] = int'(duty_g);
        din[2] = int'(duty_b);
        din[3] = int'(duty_w);
        m_live = 1'b1;
        if (reset) begin
            m_pos     = 0;
            m_act     = '{0, 0, 0, 0};
            m_pend    = '{0, 0, 0, 0};
            m_pending = 1'b0;
            e_pwm     = 4'b0000;
            e_busy    = 1'b0;
            e_ack     = 1'b0;
            e_ps      = 1'b0;
        end else begin
            boundary = tick_en && (m_pos == 254);
            e_ps  = boundary;
            e_ack = boundary && m_pending;
            if (tick_en) begin
                for (int k = 0; k < 4; k++) e_pwm[k] = level(k, m_pos, m_act[k]);
            end
            if (e_ack) begin
                m_act     = m_pend;
                m_pending = 1'b0;
            end
            if (duty_vld) begin
                m_pend    = din;
                m_pending = 1'b1;
            end
            if (tick_en) m_pos = (m_pos + 1) % 255;
            e_busy = m_pending;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            n_vec++;
            if (pwm_out !== e_pwm || busy !== e_busy || upd_ack !== e_ack || period_start !== e_ps) begin
                n_err++;
                $display("FAIL cycle_model t=%0t pwm_out=%b req=%b busy=%b req=%b upd_ack=%b req=%b period_start=%b req=%b",
                         $time, pwm_out, e_pwm, busy, e_busy, upd_ack, e_ack, period_start, e_ps);
            end
        end
    end

    // ---------------- helpers ----------------
    int hi_cnt[4];
    int ack_cnt;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int r, input int g, input int b, input int w);
        duty_vld = 1'b1;
        duty_r   = 8'(r);
        duty_g   = 8'(g);
        duty_b   = 8'(b);
        duty_w   = 8'(w);
        step();
        duty_vld = 1'b0;
    endtask

    task automatic wait_ps(input int limit, output int n, output int acks);
        n    = 0;
        acks = 0;
        forever begin
            step();
            n++;
            if (upd_ack) acks++;
            if (period_start) break;
            if (n >= limit) begin
                n_vec++;
                n_err++;
                $display("FAIL wait_ps_timeout actual=no period_start required=period_start within %0d cycles", limit);
                break;
            end
        end
    endtask

    task automatic count_period();
        for (int k = 0; k < 4; k++) hi_cnt[k] = 0;
        ack_cnt = 0;
        for (int s = 0; s < 255; s++) begin
            step();
            for (int k = 0; k < 4; k++) if (pwm_out[k]) hi_cnt[k]++;
            if (upd_ack) ack_cnt++;
        end
    endtask

    task automatic chk_hi(input string name, input int r, input int g, input int b, input int w);
        chk({name, "_r"}, hi_cnt[0], r);
        chk({name, "_g"}, hi_cnt[1], g);
        chk({name, "_b"}, hi_cnt[2], b);
        chk({name, "_w"}, hi_cnt[3], w);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int         n, a;
        int         ps_at[$];
        int         changes;
        int         rise[4];
        int         exp_rise[4];
        logic [3:0] prev;

`ifdef RGBW_PWM_STAGGER_EN
        exp_rise = '{0, 191, 127, 63};
`else
        exp_rise = '{0, 0, 0, 0};
`endif
        reset    = 1'b1;
        tick_en  = 1'b0;
        duty_vld = 1'b0;
        duty_r   = 8'd0;
        duty_g   = 8'd0;
        duty_b   = 8'd0;
        duty_w   = 8'd0;
        repeat (3) step();
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ack", int'(upd_ack), 0);
        chk("reset_ps", int'(period_start), 0);

        // free-running, all duties zero
        reset   = 1'b0;
        tick_en = 1'b1;
        wait_ps(400, n, a);
        chk("first_period_len", n, 255);
        chk("first_period_ack", a, 0);
        wait_ps(400, n, a);
        chk("period_len", n, 255);
        chk("idle_busy", int'(busy), 0);

        // strobe at cnt=10
        repeat (10) step();
        strobe(0, 1, 128, 255);
        chk("busy_after_vld", int'(busy), 1);
        wait_ps(400, n, a);
        chk("upd_wait_len", n, 244);
        chk("upd_ack_at_wrap", a, 1);
        chk("busy_cleared", int'(busy), 0);
        count_period();
        chk_hi("duty_0_1_128_255", 0, 1, 128, 255);
        chk("duty_period_ack", ack_cnt, 0);

        // last write wins
        repeat (5) step();
        strobe(50, 10, 20, 30);
        repeat (20) step();
        strobe(200, 100, 150, 250);
        wait_ps(400, n, a);
        chk("lww_ack_count", a, 1);
        count_period();
        chk_hi("lww", 200, 100, 150, 250);
        chk("lww_extra_ack", ack_cnt, 0);

        // strobe on the wrap with busy=1
        repeat (3) step();
        strobe(40, 1, 2, 3);
        repeat (250) step();
        strobe(90, 4, 5, 6);
        chk("coinc_ps", int'(period_start), 1);
        chk("coinc_ack", int'(upd_ack), 1);
        chk("coinc_busy", int'(busy), 1);
        count_period();
        chk_hi("coinc_old", 40, 1, 2, 3);
        chk("coinc_second_ack", ack_cnt, 1);
        count_period();
        chk_hi("coinc_new", 90, 4, 5, 6);
        chk("coinc_busy_end", int'(busy), 0);

        // strobe on the wrap with busy=0: deferred one period
        repeat (254) step();
        strobe(7, 8, 9, 10);
        chk("defer_ps", int'(period_start), 1);
        chk("defer_ack", int'(upd_ack), 0);
        chk("defer_busy", int'(busy), 1);
        count_period();
        chk_hi("defer_hold", 90, 4, 5, 6);
        chk("defer_ack_late", ack_cnt, 1);
        count_period();
        chk_hi("defer_new", 7, 8, 9, 10);

        // tick_en one cycle in four
        changes = 0;
        prev    = pwm_out;
        for (int i = 0; i < 2100; i++) begin
            tick_en = (i % 4 == 0);
            step();
            if (!tick_en && pwm_out !== prev) changes++;
            prev = pwm_out;
            if (period_start) ps_at.push_back(i);
        end
        tick_en = 1'b1;
        chk("slow_hold_on_idle", changes, 0);
        chk("slow_ps_count", ps_at.size(), 2);
        if (ps_at.size() >= 2) begin
            chk("slow_first_wrap", ps_at[0], 1016);
            chk("slow_period_clocks", ps_at[1] - ps_at[0], 1020);
        end

        // rising-edge placement with all duties 64
        strobe(64, 64, 64, 64);
        wait_ps(400, n, a);
        chk("edge_apply_len", n, 239);
        chk("edge_apply_ack", a, 1);
        prev = pwm_out;
        rise = '{-1, -1, -1, -1};
        for (int s = 1; s <= 255; s++) begin
            step();
            for (int k = 0; k < 4; k++) begin
                if (!prev[k] && pwm_out[k] && rise[k] < 0) rise[k] = s - 1;
            end
            prev = pwm_out;
        end
        chk("rise_ch0", rise[0], exp_rise[0]);
        chk("rise_ch1", rise[1], exp_rise[1]);
        chk("rise_ch2", rise[2], exp_rise[2]);
        chk("rise_ch3", rise[3], exp_rise[3]);

        // reset mid-period discards pending and clears outputs
        strobe(200, 200, 200, 200);
        wait_ps(400, n, a);
        repeat (50) step();
        strobe(9, 9, 9, 9);
        chk("pre_reset_busy", int'(busy), 1);
        reset = 1'b1;
        step();
        chk("mid_reset_pwm", int'(pwm_out), 0);
        chk("mid_reset_busy", int'(busy), 0);
        chk("mid_reset_ack", int'(upd_ack), 0);
        chk("mid_reset_ps", int'(period_start), 0);
        reset = 1'b0;
        wait_ps(400, n, a);
        chk("post_reset_len", n, 255);
        chk("post_reset_ack", a, 0);
        count_period();
        chk_hi("post_reset", 0, 0, 0, 0);
        chk("post_reset_period_ack", ack_cnt, 0);

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
